// File: rtl/condicionador_botoes.sv
// Input conditioner for the player push-buttons.
// Synchronises, debounces and arbitrates the buttons, then emits one one-hot pulse per press.
module condicionador_botoes #(
  parameter int unsigned N_BOTOES        = 8,
  parameter int unsigned DEBOUNCE_CICLOS = 50000,
  parameter int unsigned W_CONT          = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_in,
  output logic [N_BOTOES-1:0] botoes_pulso,
  output logic                jogada,
  output logic [N_BOTOES-1:0] botoes_estaveis,
  output logic                multiplos,
  output logic [2:0]          db_indice,
  output logic [1:0]          db_estado
);

  localparam logic [1:0] OCIOSO        = 2'd0;
  localparam logic [1:0] PULSO         = 2'd1;
  localparam logic [1:0] ESPERA_SOLTAR = 2'd2;

  localparam logic [W_CONT-1:0] CONT_MAX = W_CONT'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] sync1, sync2;
  logic [N_BOTOES-1:0] estavel, estavel_d;
  logic [W_CONT-1:0]   cnt [N_BOTOES];

  logic [N_BOTOES-1:0] sobe_c, primeiro_c;
  logic [2:0]          indice_c;

  logic [1:0]          estado, estado_nx;
  logic [N_BOTOES-1:0] pulso_nx;
  logic                jogada_nx, multiplos_nx;
  logic [2:0]          indice_nx;

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= botoes_in;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: a level is accepted only after DEBOUNCE_CICLOS consecutive disagreeing samples
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_BOTOES; i++) cnt[i] <= '0;
      estavel   <= '0;
      estavel_d <= '0;
    end else begin
      estavel_d <= estavel;
      for (int unsigned i = 0; i < N_BOTOES; i++) begin
        if (sync2[i] == estavel[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= CONT_MAX) begin
          estavel[i] <= sync2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + W_CONT'(1);
        end
      end
    end
  end

  assign botoes_estaveis = estavel;

  // Rising edges of the debounced levels; lowest index wins arbitration
  assign sobe_c     = estavel & ~estavel_d;
  assign primeiro_c = sobe_c & (~sobe_c + N_BOTOES'(1));

  always_comb begin
    indice_c = '0;
    for (int unsigned i = 0; i < N_BOTOES; i++) begin
      if (primeiro_c[i]) indice_c = 3'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      botoes_pulso <= '0;
      jogada       <= 1'b0;
      multiplos    <= 1'b0;
      db_indice    <= '0;
    end else begin
      estado       <= estado_nx;
      botoes_pulso <= pulso_nx;
      jogada       <= jogada_nx;
      multiplos    <= multiplos_nx;
      db_indice    <= indice_nx;
    end
  end

  // Next state and next registered outputs; presses are ignored until every button is released
  always_comb begin
    estado_nx    = estado;
    pulso_nx     = '0;
    jogada_nx    = 1'b0;
    multiplos_nx = 1'b0;
    indice_nx    = db_indice;
    case (estado)
      OCIOSO: begin
        if (|sobe_c) begin
          pulso_nx     = primeiro_c;
          jogada_nx    = 1'b1;
          multiplos_nx = |(sobe_c & (sobe_c - N_BOTOES'(1)));
          indice_nx    = indice_c;
          estado_nx    = PULSO;
        end
      end
      PULSO: begin
        estado_nx = (estavel == '0) ? OCIOSO : ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (estavel == '0) estado_nx = OCIOSO;
      end
      default: begin
        estado_nx = OCIOSO;
      end
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes with a short debounce window.
// Expected pulses are queued when stimulus is applied and matched when the DUT emits them.
module tb_condicionador_botoes;

  localparam int unsigned N  = 8;
  localparam int unsigned DB = 4;
  localparam int LAT = 7;  // drive just after edge k -> pulse visible just after edge k+7

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] botoes_in = '0;
  logic [N-1:0] botoes_pulso;
  logic         jogada;
  logic [N-1:0] botoes_estaveis;
  logic         multiplos;
  logic [2:0]   db_indice;
  logic [1:0]   db_estado;

  typedef struct {
    int           ciclo;
    logic [N-1:0] pulso;
    logic         mult;
    logic [2:0]   idx;
  } esperado_t;

  esperado_t fila[$];
  int n_cmp = 0;
  int n_err = 0;
  int ciclo = 0;

  condicionador_botoes #(
    .N_BOTOES(N), .DEBOUNCE_CICLOS(DB), .W_CONT(16)
  ) dut (
    .clock(clock), .reset(reset), .botoes_in(botoes_in),
    .botoes_pulso(botoes_pulso), .jogada(jogada),
    .botoes_estaveis(botoes_estaveis), .multiplos(multiplos),
    .db_indice(db_indice), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic espera_pulso(input logic [N-1:0] p, input logic m, input logic [2:0] i);
    esperado_t e;
    e.ciclo = ciclo + LAT;
    e.pulso = p;
    e.mult  = m;
    e.idx   = i;
    fila.push_back(e);
  endtask

  // Advance one edge and match any output pulse against the scoreboard
  task automatic tick();
    esperado_t e;
    @(posedge clock);
    ciclo++;
    #1;
    n_cmp++;
    if (jogada !== (|botoes_pulso)) begin
      n_err++;
      $display("FAIL jogada ciclo=%0d got=%b exp=%b", ciclo, jogada, |botoes_pulso);
    end
    n_cmp++;
    if ($countones(botoes_pulso) > 1) begin
      n_err++;
      $display("FAIL onehot ciclo=%0d got=%h", ciclo, botoes_pulso);
    end
    while (fila.size() > 0 && fila[0].ciclo < ciclo) begin
      e = fila.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missed_pulse ciclo=%0d got=none exp=%h@%0d", ciclo, e.pulso, e.ciclo);
    end
    if (botoes_pulso !== '0) begin
      n_cmp++;
      if (fila.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse ciclo=%0d got=%h exp=none", ciclo, botoes_pulso);
      end else begin
        e = fila.pop_front();
        if ({ciclo, botoes_pulso, multiplos, db_indice} !== {e.ciclo, e.pulso, e.mult, e.idx}) begin
          n_err++;
          $display("FAIL pulse ciclo=%0d got=%h/m%b/i%0d exp=%h/m%b/i%0d@%0d",
                   ciclo, botoes_pulso, multiplos, db_indice, e.pulso, e.mult, e.idx, e.ciclo);
        end
      end
    end else begin
      n_cmp++;
      if (multiplos !== 1'b0) begin
        n_err++;
        $display("FAIL multiplos_idle ciclo=%0d got=%b exp=0", ciclo, multiplos);
      end
    end
  endtask

  task automatic espera(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    espera(2);
    n_cmp++;
    if ({botoes_pulso, jogada, botoes_estaveis, multiplos, db_indice, db_estado} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h/%b/%h/%b/%0d/%0d exp=all0",
               botoes_pulso, jogada, botoes_estaveis, multiplos, db_indice, db_estado);
    end
    reset = 1'b1;
    espera(3);
    n_cmp++;
    if (db_estado !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state got=%0d exp=0", db_estado);
    end
  endtask

  task automatic test_latency();
    botoes_in = 8'h04;
    espera_pulso(8'h04, 1'b0, 3'd2);
    espera(5);
    n_cmp++;
    if (botoes_estaveis !== 8'h00) begin
      n_err++;
      $display("FAIL stable_early got=%h exp=00", botoes_estaveis);
    end
    tick();
    n_cmp++;
    if (botoes_estaveis !== 8'h04) begin
      n_err++;
      $display("FAIL stable_e5 got=%h exp=04", botoes_estaveis);
    end
    espera(4);
    n_cmp++;
    if ({db_indice, db_estado} !== {3'd2, 2'd2}) begin
      n_err++;
      $display("FAIL hold_idx_state got=%0d/%0d exp=2/2", db_indice, db_estado);
    end
    botoes_in = 8'h00;
    espera(10);
    n_cmp++;
    if ({botoes_estaveis, db_estado} !== {8'h00, 2'd0}) begin
      n_err++;
      $display("FAIL release got=%h/%0d exp=00/0", botoes_estaveis, db_estado);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] seq;
    seq = 5'b10101;
    for (int k = 0; k < 5; k++) begin
      botoes_in = {7'd0, seq[k]};
      if (k < 4) tick();
    end
    espera_pulso(8'h01, 1'b0, 3'd0);
    espera(10);
    botoes_in = 8'h00;
    espera(10);
  endtask

  task automatic test_simultaneous();
    botoes_in = 8'h90;
    espera_pulso(8'h10, 1'b1, 3'd4);
    espera(10);
    n_cmp++;
    if (botoes_estaveis !== 8'h90) begin
      n_err++;
      $display("FAIL simult_stable got=%h exp=90", botoes_estaveis);
    end
    botoes_in = 8'h00;
    espera(10);
  endtask

  task automatic test_wait_release();
    botoes_in = 8'h02;
    espera_pulso(8'h02, 1'b0, 3'd1);
    espera(10);
    botoes_in = 8'h0A;
    espera(10);
    n_cmp++;
    if ({botoes_estaveis, db_estado} !== {8'h0A, 2'd2}) begin
      n_err++;
      $display("FAIL ignore_held got=%h/%0d exp=0a/2", botoes_estaveis, db_estado);
    end
    botoes_in = 8'h00;
    espera(10);
    n_cmp++;
    if (db_estado !== 2'd0) begin
      n_err++;
      $display("FAIL back_idle got=%0d exp=0", db_estado);
    end
    botoes_in = 8'h08;
    espera_pulso(8'h08, 1'b0, 3'd3);
    espera(10);
    botoes_in = 8'h00;
    espera(10);
  endtask

  task automatic test_reset_held();
    botoes_in = 8'h20;
    espera_pulso(8'h20, 1'b0, 3'd5);
    espera(10);
    n_cmp++;
    if (db_estado !== 2'd2) begin
      n_err++;
      $display("FAIL pre_reset_state got=%0d exp=2", db_estado);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({botoes_pulso, jogada, botoes_estaveis, multiplos, db_indice, db_estado} !== '0) begin
      n_err++;
      $display("FAIL async_reset got=%h/%b/%h/%b/%0d/%0d exp=all0",
               botoes_pulso, jogada, botoes_estaveis, multiplos, db_indice, db_estado);
    end
    espera(3);
    n_cmp++;
    if ({botoes_estaveis, db_indice, db_estado} !== '0) begin
      n_err++;
      $display("FAIL reset_held got=%h/%0d/%0d exp=all0", botoes_estaveis, db_indice, db_estado);
    end
    reset = 1'b1;
    espera_pulso(8'h20, 1'b0, 3'd5);
    espera(10);
    botoes_in = 8'h00;
    espera(10);
  endtask

  task automatic test_glitch();
    botoes_in = 8'h40;
    espera(3);
    botoes_in = 8'h00;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if (botoes_estaveis !== 8'h00) begin
        n_err++;
        $display("FAIL glitch_stable ciclo=%0d got=%h exp=00", ciclo, botoes_estaveis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_simultaneous();
    test_wait_release();
    test_reset_held();
    test_glitch();
    espera(3);
    n_cmp++;
    if (fila.size() != 0) begin
      n_err++;
      $display("FAIL pending_pulses got=%0d exp=0", fila.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
